// File: rtl/scnn_pkg.sv
// Shared widths, types and FSM state encoding for the SCNN output drain.
package scnn_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned ACT_W = 16;
    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } drain_state_t;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACT_W-1:0] act_t;

endpackage

// File: rtl/scnn_output_drain_if.sv
// Valid/ready result stream from the output drain to the next-layer consumer.
interface scnn_output_drain_if;
    import scnn_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [ACT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/scnn_relu_quant.sv
// Per-element requantisation: arithmetic shift, saturate to 16 bits, ReLU.
module scnn_relu_quant
    import scnn_pkg::*;
#(
    parameter int unsigned PARAM_SHIFT = 8
) (
    input  acc_t acc_in,
    output act_t act_out
);

    localparam acc_t SAT_HI = acc_t'(32767);

    acc_t shifted;

    // Negative values collapse to zero via ReLU, so only the upper clamp is needed.
    always_comb begin
        shifted = acc_in >>> PARAM_SHIFT;
        if (shifted[ACC_W-1]) begin
            act_out = '0;
        end else if (shifted > SAT_HI) begin
            act_out = act_t'(SAT_HI);
        end else begin
            act_out = act_t'(shifted);
        end
    end

endmodule

// File: rtl/scnn_output_drain.sv
// Captures merged accumulators, requantises them and streams results in dense or zero-skipping order.
module scnn_output_drain
    import scnn_pkg::*;
#(
    parameter int unsigned PARAM_IP_SIZE = 16,
    parameter int unsigned PARAM_SHIFT   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [PARAM_IP_SIZE-1:0][ACC_W-1:0] acc_in,
    input  logic                                compress_en,
    scnn_output_drain_if.master                 out_if,
    output logic                                busy,
    output logic                                done,
    output logic [IDX_W-1:0]                    nz_count
);

    localparam int unsigned N     = PARAM_IP_SIZE;
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    act_t relu_out [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_quant
        scnn_relu_quant #(
            .PARAM_SHIFT(PARAM_SHIFT)
        ) u_relu_quant (
            .acc_in (acc_in[gi]),
            .act_out(relu_out[gi])
        );
    end

    drain_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    act_t             data_buf_q [N];
    act_t             data_buf_d [N];
    logic [N-1:0]     mask_q, mask_d;
    logic             cmp_q, cmp_d;
    logic [IDX_W-1:0] nz_q, nz_d;

    logic [SEL_W-1:0] sel;
    logic [IDX_W:0]   idx_p1;
    logic [N-1:0]     mask_rest;
    logic             eligible;
    logic             last_hit;
    logic             consume;
    logic [IDX_W-1:0] nz_sum;

    always_comb begin
        sel       = idx_q[SEL_W-1:0];
        idx_p1    = {1'b0, idx_q} + (IDX_W+1)'(1);
        mask_rest = mask_q >> idx_p1;
        eligible  = !cmp_q || mask_q[sel];
        // Compressed mode looks ahead: last when no set mask bit remains above idx.
        last_hit  = cmp_q ? ~|mask_rest : (idx_q == IDX_W'(N-1));
        consume   = !eligible || out_if.out_ready;
        nz_sum    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            nz_sum = nz_sum + IDX_W'(mask_q[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_buf_d = data_buf_q;
        mask_d     = mask_q;
        cmp_d      = cmp_q;
        nz_d       = nz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        data_buf_d[i] = relu_out[i];
                        mask_d[i]     = (relu_out[i] != '0);
                    end
                    cmp_d   = compress_en;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (consume) begin
                    if (idx_q == IDX_W'(N-1)) begin
                        nz_d    = nz_sum;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_p1[IDX_W-1:0];
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid = (state_q == SCAN) && eligible;
        out_if.out_data  = (state_q == SCAN) ? data_buf_q[sel] : '0;
        out_if.out_idx   = (state_q == SCAN) ? idx_q : '0;
        out_if.out_last  = out_if.out_valid && last_hit;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        nz_count         = nz_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_buf_q <= '{default: '0};
            mask_q     <= '0;
            cmp_q      <= 1'b0;
            nz_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_buf_q <= data_buf_d;
            mask_q     <= mask_d;
            cmp_q      <= cmp_d;
            nz_q       <= nz_d;
        end
    end

endmodule
